// File: rtl/adc_capture_ctrl_if.sv
// Streaming interface between the ADC capture controller and the OFDM receive path.
// The master drives a sample with valid/last; the slave accepts it with ready.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 10
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: owns the single-port sample RAM. It arms on start, waits
// for trig, writes NUM_SAMPLES qualified samples to addresses 0..N-1, then streams
// the buffer out through a 2-entry skid buffer that hides the 1-clk RAM read latency.
module adc_capture_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 10,
  parameter int NUM_SAMPLES = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              trig,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              rd_start,
  adc_capture_ctrl_if.master out_if,
  output logic              busy,
  output logic              done,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE,
    S_READ
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic              rd_all;       // every address has been issued this readout
  logic              rd_pend;      // a read issued last cycle lands in ram_dout now
  logic              rd_pend_last; // ...and it is the read of LAST_ADDR
  logic              wr_en;
  logic              rd_en;
  logic              pop;
  logic              room;
  logic [2:0]        occ;

  // Skid buffer: two entries of {data, last}, head at sk_rptr.
  logic [DATA_W-1:0] sk_data [2];
  logic [1:0]        sk_last;
  logic [1:0]        sk_cnt;
  logic              sk_wptr;
  logic              sk_rptr;
  logic              out_valid_i;

  assign out_valid_i      = (sk_cnt != 2'd0);
  assign out_if.out_valid = out_valid_i;
  assign out_if.out_data  = sk_data[sk_rptr];
  assign out_if.out_last  = out_valid_i && sk_last[sk_rptr];

  // Next state and the per-cycle RAM access decision.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    pop       = out_valid_i && out_if.out_ready;
    // Entries held after this edge, counting the read already in flight; a new
    // read only goes out if its data is guaranteed a slot when it lands.
    occ       = {1'b0, sk_cnt} + {2'b0, rd_pend} - {2'b0, pop};
    room      = (occ < 3'd2);
    case (state)
      S_IDLE: if (start) state_nxt = S_ARM;
      S_ARM:  if (trig)  state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (adc_valid) begin
          wr_en = 1'b1;
          if (wr_cnt == LAST_ADDR) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_ARM;
        end else if (rd_start) begin
          // Address 0 is read in the rd_start cycle itself so the first beat
          // appears two clocks later.
          state_nxt = S_READ;
          rd_en     = 1'b1;
        end
      end
      S_READ: begin
        if (!rd_all && room) rd_en = 1'b1;
        if (pop && out_if.out_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort || reset) begin
      state_nxt = S_IDLE;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
    end
  end

  // RAM port: driven only while an access is made, otherwise parked at zero.
  assign ram_ce  = wr_en || rd_en;
  assign ram_oce = ram_ce;
  assign ram_wre = wr_en;
  assign ram_ad  = wr_en ? wr_cnt : (rd_en ? rd_cnt : '0);
  assign ram_din = wr_en ? adc_data : '0;

  // State register, registered status decodes and address counters.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      rd_all       <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_ARM) || (state_nxt == S_CAPTURE) || (state_nxt == S_READ);
      done  <= (state_nxt == S_DONE);

      if (state_nxt != S_CAPTURE) wr_cnt <= '0;
      else if (wr_en)             wr_cnt <= wr_cnt + 1'b1;

      if (state_nxt != S_READ) begin
        rd_cnt <= '0;
        rd_all <= 1'b0;
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
        rd_all <= (rd_cnt == LAST_ADDR);
      end

      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && (rd_cnt == LAST_ADDR);
    end
  end

  // Skid buffer pointers and occupancy; abort flushes anything buffered or in flight.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      sk_cnt  <= 2'd0;
      sk_wptr <= 1'b0;
      sk_rptr <= 1'b0;
    end else begin
      if (rd_pend) sk_wptr <= ~sk_wptr;
      if (pop)     sk_rptr <= ~sk_rptr;
      sk_cnt <= sk_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  // Skid buffer storage: captures the RAM read data the cycle it becomes valid.
  always_ff @(posedge clk) begin
    // NOTE: the storage is not reset; an entry is only observed once sk_cnt marks it valid.
    if (rd_pend && !abort) begin
      sk_data[sk_wptr] <= ram_dout;
      sk_last[sk_wptr] <= rd_pend_last;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl with N=16 samples and a behavioural
// single-port RAM (1-clk read latency, output held while CE is low).
module tb_adc_capture_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 10;
  localparam int N      = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort, trig, adc_valid, rd_start;
  logic [DATA_W-1:0] adc_data;
  logic              busy, done, ram_ce, ram_oce, ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  adc_capture_ctrl_if #(.DATA_W(DATA_W)) out_if ();

  adc_capture_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_SAMPLES(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .trig     (trig),
    .adc_valid(adc_valid),
    .adc_data (adc_data),
    .rd_start (rd_start),
    .out_if   (out_if),
    .busy     (busy),
    .done     (done),
    .ram_ce   (ram_ce),
    .ram_oce  (ram_oce),
    .ram_wre  (ram_wre),
    .ram_ad   (ram_ad),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural sample RAM.
  logic [DATA_W-1:0] ram_mem [2**ADDR_W];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
      ram_dout <= ram_mem[ram_ad];
    end
  end

  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] exp_mem [N];
  bit                pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic              start, trig, adc_valid, rd_start, abort;
    logic [DATA_W-1:0] adc_data;
    logic              exp_busy, exp_done, exp_wre, exp_ce, exp_ovalid;
    logic [ADDR_W-1:0] exp_ad;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    abort     = 1'b0;
    trig      = 1'b0;
    adc_valid = 1'b0;
    rd_start  = 1'b0;
    adc_data  = '0;
  endtask

  // Arm, trigger and write N samples of value i*mul+add, optionally with gaps in adc_valid.
  task automatic do_capture(input int mul, input int add, input bit gaps);
    tick(); idle_inputs(); start = 1'b1;
    @(negedge clk);
    tick(); start = 1'b0; trig = 1'b1;
    @(negedge clk);
    check("arm_busy", busy, 1);
    tick(); trig = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 3 == 1)) begin
        adc_valid = 1'b0;
        @(negedge clk);
        check("cap_gap_wre", ram_wre, 0);
        tick();
      end
      adc_valid  = 1'b1;
      adc_data   = DATA_W'(i * mul + add);
      exp_mem[i] = adc_data;
      @(negedge clk);
      check("cap_wre", ram_wre, 1);
      check("cap_oce", ram_oce, 1);
      check("cap_ad", ram_ad, i);
      check("cap_din", ram_din, exp_mem[i]);
      tick();
    end
    adc_valid = 1'b0;
    @(negedge clk);
    check("cap_done", done, 1);
    check("cap_busy", busy, 0);
  endtask

  // Stream the buffer out. mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic read_out(input int mode);
    int                idx  = 0;
    int                c    = 1;
    bit                held = 1'b0;
    logic [DATA_W-1:0] hd   = '0;
    logic              hl   = 1'b0;
    tick(); idle_inputs(); rd_start = 1'b1;
    out_if.out_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? pat[0] : 1'(($urandom_range(0, 1))));
    @(negedge clk);
    check("rd_issue_ce", ram_ce, 1);
    check("rd_issue_ad", ram_ad, 0);
    check("rd_issue_wre", ram_wre, 0);
    while (idx < N && c < 200) begin
      tick(); rd_start = 1'b0;
      case (mode)
        0:       out_if.out_ready = 1'b1;
        1:       out_if.out_ready = pat[c % 4];
        default: out_if.out_ready = 1'(($urandom_range(0, 1)));
      endcase
      @(negedge clk);
      if (c == 1) check("rd_lat_c1_valid", out_if.out_valid, 0);
      if (c == 2) check("rd_lat_c2_valid", out_if.out_valid, 1);
      if (mode == 0 && c >= 2) check("rd_no_bubble", out_if.out_valid, 1);
      if (held) begin
        check("stall_valid", out_if.out_valid, 1);
        check("stall_data", out_if.out_data, hd);
        check("stall_last", out_if.out_last, hl);
      end
      held = 1'b0;
      if (out_if.out_valid) begin
        check("rd_data", out_if.out_data, exp_mem[idx]);
        check("rd_last", out_if.out_last, (idx == N - 1) ? 1 : 0);
        if (out_if.out_ready) begin
          idx++;
        end else begin
          held = 1'b1;
          hd   = out_if.out_data;
          hl   = out_if.out_last;
        end
      end
      c++;
    end
    check("rd_beats", idx, N);
    tick(); out_if.out_ready = 1'b0;
    @(negedge clk);
    check("rd_end_done", done, 1);
    check("rd_end_busy", busy, 0);
    check("rd_end_valid", out_if.out_valid, 0);
  endtask

  initial begin
    void'($urandom(1));
    idle_inputs();
    out_if.out_ready = 1'b0;
    reset = 1'b1;

    // Control vectors, starting in DONE with a full buffer.
    //           start trig valid rd_st abort data  busy done wre ce  ov   ad
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd500, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_if.out_valid, 0);
    check("rst_last", out_if.out_last, 0);
    check("rst_ce", ram_ce, 0);
    check("rst_oce", ram_oce, 0);
    check("rst_wre", ram_wre, 0);
    check("rst_ad", ram_ad, 0);
    check("rst_din", ram_din, 0);
    tick(); reset = 1'b0;

    // 1: capture i*3, stream out with ready held high.
    do_capture(3, 0, 1'b0);
    read_out(0);

    // 2: stream again with ready toggling 1,0,0,1.
    read_out(1);

    // 3: abort at capture sample 7, then a fresh capture restarts at address 0.
    tick(); idle_inputs(); start = 1'b1;
    @(negedge clk);
    tick(); start = 1'b0; trig = 1'b1;
    @(negedge clk);
    tick(); trig = 1'b0;
    for (int i = 0; i < 8; i++) begin
      adc_valid = 1'b1;
      adc_data  = DATA_W'(100 + i);
      abort     = (i == 7);
      @(negedge clk);
      if (i == 7) begin
        check("abort_wre", ram_wre, 0);
        check("abort_ce", ram_ce, 0);
      end else begin
        check("pre_abort_ad", ram_ad, i);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    do_capture(7, 2, 1'b1);
    read_out(2);

    // 4/5: control vectors from DONE.
    for (int r = 0; r < 9; r++) begin
      tick();
      start     = vecs[r].start;
      trig      = vecs[r].trig;
      adc_valid = vecs[r].adc_valid;
      rd_start  = vecs[r].rd_start;
      abort     = vecs[r].abort;
      adc_data  = vecs[r].adc_data;
      out_if.out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_busy", r), busy, vecs[r].exp_busy);
      check($sformatf("vec%0d_done", r), done, vecs[r].exp_done);
      check($sformatf("vec%0d_wre", r), ram_wre, vecs[r].exp_wre);
      check($sformatf("vec%0d_ce", r), ram_ce, vecs[r].exp_ce);
      check($sformatf("vec%0d_valid", r), out_if.out_valid, vecs[r].exp_ovalid);
      if (vecs[r].exp_wre) begin
        check($sformatf("vec%0d_ad", r), ram_ad, vecs[r].exp_ad);
        check($sformatf("vec%0d_din", r), ram_din, vecs[r].adc_data);
      end
    end
    exp_mem[0] = 10'd500;
    for (int i = 1; i < N; i++) begin
      tick(); idle_inputs();
      adc_valid  = 1'b1;
      adc_data   = DATA_W'(900 - 11 * i);
      exp_mem[i] = adc_data;
      @(negedge clk);
      check("vcap_ad", ram_ad, i);
      check("vcap_valid", out_if.out_valid, 0);
    end
    tick(); idle_inputs();
    @(negedge clk);
    check("vcap_done", done, 1);
    check("vcap_valid_after", out_if.out_valid, 0);
    read_out(0);

    // 6: abort while a beat is stalled.
    tick(); idle_inputs(); rd_start = 1'b1; out_if.out_ready = 1'b0;
    @(negedge clk);
    tick(); rd_start = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("stall6_valid", out_if.out_valid, 1);
    check("stall6_data", out_if.out_data, exp_mem[0]);
    tick(); abort = 1'b1;
    @(negedge clk);
    check("abort6_valid_pre", out_if.out_valid, 1);
    tick(); abort = 1'b0;
    @(negedge clk);
    check("abort6_valid", out_if.out_valid, 0);
    check("abort6_busy", busy, 0);
    check("abort6_done", done, 0);
    check("abort6_ce", ram_ce, 0);

    // Reset in the middle of a capture.
    tick(); start = 1'b1;
    @(negedge clk);
    tick(); start = 1'b0; trig = 1'b1;
    @(negedge clk);
    tick(); trig = 1'b0; adc_valid = 1'b1; adc_data = 10'd77;
    @(negedge clk);
    check("prerst_wre", ram_wre, 1);
    tick(); reset = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", out_if.out_valid, 0);
    check("midrst_last", out_if.out_last, 0);
    check("midrst_ce", ram_ce, 0);
    check("midrst_wre", ram_wre, 0);
    check("midrst_ad", ram_ad, 0);
    check("midrst_din", ram_din, 0);
    tick(); reset = 1'b0; idle_inputs();
    @(negedge clk);
    check("postrst_busy", busy, 0);
    check("postrst_wre", ram_wre, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
